// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver with majority-vote bit sampling,
// configurable 5..8 data bits, none/even/odd parity, 1 or 2 stop bits, single holding register.
`default_nettype none

module uart_receiver (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_ce,
  input  logic [1:0] i_parity,    // 0 none, 1 even, 2 odd
  input  logic       i_stopBits,  // 0 one stop bit, 1 two stop bits
  input  logic [1:0] i_dataBits,  // 0..3 -> 5..8 data bits
  input  logic       i_rd,
  output logic [7:0] o_data,
  output logic       o_avail,
  output logic       o_parityErr,
  output logic       o_frameErr,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_nxt;
  logic       rx_meta, rx_sync;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic       samp7, samp8;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic [1:0] cfg_bits;
  logic [7:0] shreg;
  logic       par_bit;
  logic       stop_err;

  logic vote, at_mid, at_end, last_data, last_stop, done;
  logic parity_err_now, frame_err_now;

  always_comb begin
    vote      = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);
    at_mid    = i_ce && (tick_cnt == 4'd9);
    at_end    = i_ce && (tick_cnt == 4'd15);
    last_data = (bit_cnt == ({1'b0, cfg_bits} + 3'd4));
    last_stop = !cfg_stop2 || bit_cnt[0];
    parity_err_now = (cfg_parity != PARITY_NONE) &&
                     (^shreg ^ par_bit ^ (cfg_parity == PARITY_ODD));
    // At completion the current vote is the last stop bit itself.
    frame_err_now = stop_err | ~vote;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:   if (i_ce && !rx_sync) state_nxt = START;
      START:  begin
        if (at_mid && vote) state_nxt = IDLE;
        else if (at_end)    state_nxt = DATA;
      end
      DATA:   if (at_end && last_data)
                state_nxt = (cfg_parity == PARITY_NONE) ? STOP : PARITY;
      PARITY: if (at_end) state_nxt = STOP;
      STOP:   if (at_mid && last_stop) begin
                done      = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      samp7      <= 1'b1;
      samp8      <= 1'b1;
      cfg_parity <= PARITY_NONE;
      cfg_stop2  <= 1'b0;
      cfg_bits   <= 2'd3;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      if (state == IDLE) begin
        if (i_ce && !rx_sync) begin
          cfg_parity <= i_parity;
          cfg_stop2  <= i_stopBits;
          cfg_bits   <= i_dataBits;
          tick_cnt   <= 4'd0;
          bit_cnt    <= 3'd0;
          shreg      <= 8'h00;
          stop_err   <= 1'b0;
        end
      end else if (i_ce) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd7) samp7 <= rx_sync;
        if (tick_cnt == 4'd8) samp8 <= rx_sync;
        if (tick_cnt == 4'd9) begin
          case (state)
            DATA:    shreg[bit_cnt] <= vote;
            PARITY:  par_bit <= vote;
            STOP:    if (!vote) stop_err <= 1'b1;
            default: ;
          endcase
        end
        // bit_cnt restarts whenever the bit period ends in a new state.
        if (tick_cnt == 4'd15) begin
          if (state_nxt != state) bit_cnt <= 3'd0;
          else                    bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data      <= 8'h00;
      o_avail     <= 1'b0;
      o_parityErr <= 1'b0;
      o_frameErr  <= 1'b0;
      o_overrun   <= 1'b0;
    end else if (done) begin
      if (!o_avail || i_rd) begin
        o_data      <= shreg;
        o_parityErr <= parity_err_now;
        o_frameErr  <= frame_err_now;
        o_avail     <= 1'b1;
        if (i_rd) o_overrun <= 1'b0;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (i_rd && o_avail) begin
      o_avail   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: UART_Receiver

Interface
REQ-001 SHALL have port i_clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-004 SHALL have port i_ce, input, 1 bit: one-cycle sample enable pulsing at 16x baud, driven by UART_Baud o_rxce.
REQ-005 SHALL have port i_parity, input, UART_Types Parity: Parity_None, Parity_Even or Parity_Odd.
REQ-006 SHALL have port i_stopBits, input, UART_Types StopBits: StopBits_1 or StopBits_2.
REQ-007 SHALL have port i_dataBits, input, UART_Types DataBits: DataBits_5, DataBits_6, DataBits_7 or DataBits_8.
REQ-008 SHALL have port i_rd, input, 1 bit: read acknowledge; consumes the held byte.
REQ-009 SHALL have port o_data, output, 8 bits: last accepted byte, right-justified, unused upper bits 0.
REQ-010 SHALL have port o_avail, output, 1 bit: a byte is held and unread.
REQ-011 SHALL have port o_parityErr, output, 1 bit: parity error for the held byte.
REQ-012 SHALL have port o_frameErr, output, 1 bit: stop-bit error for the held byte.
REQ-013 SHALL have port o_overrun, output, 1 bit: sticky; a frame was lost while o_avail was 1.
REQ-014 SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL pass i_rx through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; tick counter 4 bits; bit counter 3 bits.
REQ-017 SHALL, in IDLE on an i_ce tick with synchronized line 0, latch i_parity, i_stopBits and i_dataBits for the frame, clear the tick counter and enter START.
REQ-018 SHALL sample each bit as the majority of the synchronized line at ticks 7, 8 and 9 of its 16-tick bit period; the tick counter advances only on i_ce.
REQ-019 SHALL, in START at tick 9, return to IDLE if the voted value is 1 (false start, no flags change), else enter DATA at tick 15.
REQ-020 SHALL shift data LSB-first, take exactly N=5..8 bits per latched config, then enter PARITY if parity is enabled, else STOP.
REQ-021 SHALL flag parity error when XOR(data, parity bit) is 1 for Even or 0 for Odd.
REQ-022 SHALL, in STOP, flag frame error if any voted stop bit is 0; with StopBits_2, check both.
REQ-023 SHALL complete the frame at tick 9 of the last stop bit and return to IDLE in the same cycle, so a start edge arriving immediately afterwards is detected.
REQ-024 SHALL, on completion with o_avail=0 or i_rd=1, load o_data, o_parityErr and o_frameErr and set o_avail, all visible on the next cycle.
REQ-025 SHALL, on completion with o_avail=1 and i_rd=0, discard the new frame, keep o_data and the error flags unchanged, and set o_overrun.
REQ-026 SHALL, on i_rd=1 with no completion in the same cycle, clear o_avail and o_overrun on the next cycle; o_data is retained.
REQ-027 SHALL ignore i_rd when o_avail=0.
REQ-028 SHALL ignore changes to the configuration inputs mid-frame; they take effect at the next start detection.

Reset
REQ-029 SHALL, while i_reset=1, force the FSM to IDLE, clear both counters and set o_data=0x00, o_avail=0, o_parityErr=0, o_frameErr=0, o_overrun=0, o_busy=0.
REQ-030 SHALL, on reset asserted mid-frame, abandon the frame with no output update; reception restarts on the next falling edge after reset deasserts.

Verification
REQ-031 SHALL be verified with 8N1, byte 0xA5 sent at 16x ce -> o_data=0xA5, o_avail=1, no error flags, o_busy=0 after completion.
REQ-032 SHALL be verified with 7E2, byte 0x35 sent with wrong parity bit -> o_data=0x35, o_parityErr=1; a second frame with stop2=0 -> o_frameErr=1.
REQ-033 SHALL be verified with a 0 glitch of 4 ce ticks on an idle line -> FSM returns to IDLE, o_avail remains 0.
REQ-034 SHALL be verified with two frames 0x11 then 0x22 sent without i_rd -> o_data=0x11, o_overrun=1; i_rd then clears o_avail and o_overrun.
REQ-035 SHALL be verified with i_rd asserted in the exact completion cycle of 0x22 while 0x11 is held -> o_data=0x22, o_avail=1, o_overrun=0.
REQ-036 SHALL be verified with i_reset pulsed during bit 3 of a frame and a 0x5A frame sent afterwards -> o_avail=0 after reset, then o_data=0x5A with no errors.
